// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared encodings, FSM states and IF/ID record for fetch_stage
package fetch_stage_pkg;

  localparam logic [15:0] NOP_ENC = 16'h0800;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_next;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_skid.sv
// rtl/fetch_stage_skid.sv - one-entry holder for a word fetched while decode is stalled
module fetch_stage_skid
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  clear,
  input  ifid_t din,
  output logic  full,
  output ifid_t dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, imem fetch, IF/ID register
// Optional one-entry skid buffer enabled by defining FETCH_SKID_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        imem_err,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] instr,
  output logic [15:0] pc_next,
  output logic        if_valid,
  output logic        err
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, pc_inc;
  ifid_t       ifid_q, ifid_d, word, bubble, skid_data;
  logic        err_q, err_d, accept, skid_full;

  assign pc_inc = pc_q + 16'd2;
  assign word   = '{instr: imem_data, pc_next: pc_inc, valid: !imem_err};
  assign bubble = '{instr: NOP_INSTR, pc_next: ifid_q.pc_next, valid: 1'b0};

`ifdef FETCH_SKID_EN
  localparam bit SKID_EN = 1'b1;
  logic skid_load, skid_clear;

  // Park a word only on a plain stalled cycle; redirect/halt make it wrong-path.
  assign skid_load  = (state_q == FETCH) && !redirect && !halt && stall && accept;
  assign skid_clear = redirect || halt || !stall || (state_q == HALTED);

  fetch_stage_skid u_skid (
    .clk   (clk),
    .rst_n (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (word),
    .full  (skid_full),
    .dout  (skid_data)
  );
`else
  localparam bit SKID_EN = 1'b0;
  assign skid_full = 1'b0;
  assign skid_data = bubble;
`endif

  assign imem_req  = rst && (state_q == FETCH) && !skid_full && (SKID_EN || !stall);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_rdy;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    err_d   = err_q;
    if (state_q == FETCH) begin
      if (redirect) begin
        pc_d   = redirect_pc;
        ifid_d = bubble;
        err_d  = err_q | redirect_pc[0];
      end else if (halt) begin
        state_d = HALTED;
        ifid_d  = bubble;
      end else begin
        if (accept) begin
          pc_d  = pc_inc;
          err_d = err_q | imem_err;
        end
        if (!stall) begin
          if (skid_full)   ifid_d = skid_data;
          else if (accept) ifid_d = word;
          else             ifid_d = bubble;
        end
      end
    end else if (!stall) begin
      ifid_d = bubble;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ifid_q  <= '{instr: NOP_INSTR, pc_next: RESET_PC, valid: 1'b0};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      err_q   <= err_d;
    end
  end

  assign instr    = ifid_q.instr;
  assign pc_next  = ifid_q.pc_next;
  assign if_valid = ifid_q.valid;
  assign err      = err_q;

endmodule
